branch_seq_core: RTL and testbench

- Parametrised multi-cycle sequencer: fetch, decode, compare, branch.
- Generalises the team's 5-bit-PC compare/branch machine.
  - Separate instruction memory and register file.
  - Configurable width and depth.
  - Signed or unsigned compare.
  - Proper halt, illegal-opcode and program-load handshakes.
- Sits under the CSE-Bubble top as the control engine. The bench loads the program through the load port, then pulses start.

---
 rtl/branch_seq_pkg.sv | 34 +++
 rtl/branch_seq_cmp.sv | 31 +++
 rtl/branch_seq_core.sv | 213 +++++++++++++++++++++
 tb/tb_branch_seq_core.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_seq_pkg.sv
// Shared opcodes, FSM states and instruction field positions for the branch sequencer.
package branch_seq_pkg;

  localparam logic [5:0] OP_ADD  = 6'd12;
  localparam logic [5:0] OP_SUB  = 6'd13;
  localparam logic [5:0] OP_BEQ  = 6'd14;
  localparam logic [5:0] OP_BNE  = 6'd15;
  localparam logic [5:0] OP_BGT  = 6'd16;
  localparam logic [5:0] OP_BGE  = 6'd17;
  localparam logic [5:0] OP_BLT  = 6'd18;
  localparam logic [5:0] OP_BLE  = 6'd19;
  localparam logic [5:0] OP_J    = 6'd20;
  localparam logic [5:0] OP_JAL  = 6'd21;
  localparam logic [5:0] OP_SLT  = 6'd22;
  localparam logic [5:0] OP_HALT = 6'd63;

  localparam int unsigned OPC_LSB = 26;
  localparam int unsigned RD_LSB  = 21;
  localparam int unsigned RS_LSB  = 16;
  localparam int unsigned RT_LSB  = 11;
  localparam int unsigned IDX_W   = 5;
  localparam int unsigned LINK_REG = 31;

  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, HALT} state_e;

  function automatic logic is_branch(input logic [5:0] opcode);
    return (opcode >= OP_BEQ) && (opcode <= OP_BLE);
  endfunction

  function automatic logic is_alu(input logic [5:0] opcode);
    return (opcode == OP_ADD) || (opcode == OP_SUB) || (opcode == OP_SLT);
  endfunction

endpackage

// File: rtl/branch_seq_cmp.sv
// Combinational compare unit for conditional branches and SLT.
module branch_seq_cmp
  import branch_seq_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter bit          SIGNED_CMP = 1'b0
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [5:0]        opcode,
  output logic              taken
);

  logic eq, lt;

  always_comb begin
    eq = (a == b);
    if (SIGNED_CMP) lt = ($signed(a) < $signed(b));
    else            lt = (a < b);
    case (opcode)
      OP_BEQ:         taken = eq;
      OP_BNE:         taken = !eq;
      OP_BGT:         taken = !lt && !eq;
      OP_BGE:         taken = !lt;
      OP_BLT, OP_SLT: taken = lt;
      OP_BLE:         taken = lt || eq;
      default:        taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_seq_core.sv
// Multi-cycle fetch/decode/exec sequencer with compare-and-branch.
// Optional BRANCH_STATS_EN adds saturating taken/exec counters.
module branch_seq_core
  import branch_seq_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned IMEM_DEPTH = 32,
  parameter int unsigned NREGS      = 32,
  parameter bit          SIGNED_CMP = 1'b0,
  localparam int unsigned PC_W      = $clog2(IMEM_DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_en,
  input  logic [PC_W-1:0]   load_addr,
  input  logic [31:0]       load_data,
  input  logic              start,
  output logic [PC_W-1:0]   pc,
  output logic              busy,
  output logic              halted,
  output logic              illegal,
  output logic [DATA_W-1:0] dbg_a,
  output logic [DATA_W-1:0] dbg_b,
  output logic [DATA_W-1:0] dbg_result
`ifdef BRANCH_STATS_EN
  ,
  output logic [15:0]       taken_cnt,
  output logic [15:0]       exec_cnt
`endif
);

  localparam int unsigned RIDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d, pc_inc, imm_pc, tgt_pc;
  logic [31:0]       ir_q, ir_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, res_q, res_d, alu_res;
  logic [DATA_W-1:0] rs_val, b_val;
  logic              illegal_q, illegal_d;
  logic              cmp_taken, idle_like, start_ok;
  logic [5:0]        opc;
  logic [IDX_W-1:0]  rd, rs, rt, b_idx, wr_idx;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;

  logic [31:0]       imem [IMEM_DEPTH];
  logic [DATA_W-1:0] rf_q [NREGS];

  assign opc    = ir_q[OPC_LSB +: 6];
  assign rd     = ir_q[RD_LSB +: IDX_W];
  assign rs     = ir_q[RS_LSB +: IDX_W];
  assign rt     = ir_q[RT_LSB +: IDX_W];
  assign imm_pc = PC_W'({{16{ir_q[15]}}, ir_q[15:0]});
  assign tgt_pc = PC_W'(ir_q[25:0]);
  assign pc_inc = pc_q + PC_W'(1);

  assign idle_like = (state_q == IDLE) || (state_q == HALT);
  assign start_ok  = idle_like && start;

  // Register 0 and out-of-range indices read as zero.
  assign b_idx  = is_alu(opc) ? rt : rd;
  assign rs_val = (rs != '0 && 32'(rs) < NREGS) ? rf_q[rs[RIDX_W-1:0]] : '0;
  assign b_val  = (b_idx != '0 && 32'(b_idx) < NREGS) ? rf_q[b_idx[RIDX_W-1:0]] : '0;

  branch_seq_cmp #(
    .DATA_W     (DATA_W),
    .SIGNED_CMP (SIGNED_CMP)
  ) u_cmp (
    .a      (a_q),
    .b      (b_q),
    .opcode (opc),
    .taken  (cmp_taken)
  );

  always_comb begin
    case (opc)
      OP_ADD:  alu_res = a_q + b_q;
      OP_SUB:  alu_res = a_q - b_q;
      default: alu_res = {{(DATA_W-1){1'b0}}, cmp_taken};
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    illegal_d = illegal_q;
    wr_en     = 1'b0;
    wr_idx    = rd;
    wr_data   = alu_res;
    unique case (state_q)
      IDLE, HALT: begin
        if (start) begin
          state_d   = FETCH;
          pc_d      = '0;
          illegal_d = 1'b0;
        end
      end
      FETCH: begin
        ir_d    = imem[pc_q];
        state_d = DECODE;
      end
      DECODE: begin
        a_d     = rs_val;
        b_d     = b_val;
        state_d = EXEC;
      end
      EXEC: begin
        state_d = FETCH;
        if (is_alu(opc)) begin
          wr_en = 1'b1;
          res_d = alu_res;
          pc_d  = pc_inc;
        end else if (is_branch(opc)) begin
          pc_d = cmp_taken ? pc_inc + imm_pc : pc_inc;
        end else if (opc == OP_J) begin
          pc_d = tgt_pc;
        end else if (opc == OP_JAL) begin
          pc_d    = tgt_pc;
          wr_en   = 1'b1;
          wr_idx  = IDX_W'(LINK_REG);
          wr_data = DATA_W'(pc_inc);
        end else if (opc == OP_HALT) begin
          state_d = HALT;
        end else begin
          state_d   = HALT;
          illegal_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      a_q       <= a_d;
      b_q       <= b_d;
      res_q     <= res_d;
      illegal_q <= illegal_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else if (wr_en && wr_idx != '0 && 32'(wr_idx) < NREGS) begin
      rf_q[wr_idx[RIDX_W-1:0]] <= wr_data;
    end
  end

  // Program memory is deliberately left out of reset so a loaded program survives it.
  always_ff @(posedge clk) begin
    if (load_en && idle_like) imem[load_addr] <= load_data;
  end

  assign pc         = pc_q;
  assign busy       = (state_q == FETCH) || (state_q == DECODE) || (state_q == EXEC);
  assign halted     = (state_q == HALT);
  assign illegal    = illegal_q;
  assign dbg_a      = a_q;
  assign dbg_b      = b_q;
  assign dbg_result = res_q;

`ifdef BRANCH_STATS_EN
  logic [15:0] taken_cnt_q, taken_cnt_d, exec_cnt_q, exec_cnt_d;
  logic        flow_taken;

  assign flow_taken = (is_branch(opc) && cmp_taken) || (opc == OP_J) || (opc == OP_JAL);

  always_comb begin
    taken_cnt_d = taken_cnt_q;
    exec_cnt_d  = exec_cnt_q;
    if (start_ok) begin
      taken_cnt_d = '0;
      exec_cnt_d  = '0;
    end else if (state_q == EXEC) begin
      if (exec_cnt_q != 16'hFFFF) exec_cnt_d = exec_cnt_q + 16'd1;
      if (flow_taken && taken_cnt_q != 16'hFFFF) taken_cnt_d = taken_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      taken_cnt_q <= '0;
      exec_cnt_q  <= '0;
    end else begin
      taken_cnt_q <= taken_cnt_d;
      exec_cnt_q  <= exec_cnt_d;
    end
  end

  assign taken_cnt = taken_cnt_q;
  assign exec_cnt  = exec_cnt_q;
`else
  logic unused_start_ok;
  assign unused_start_ok = start_ok;
`endif

endmodule

// File: tb/tb_branch_seq_core.sv
// Directed bench: unsigned and signed-compare instances share one program stream.
module tb_branch_seq_core;
  import branch_seq_pkg::*;

  localparam int unsigned DW  = 32;
  localparam int unsigned PCW = 5;

  logic           clk = 1'b0;
  logic           reset, load_en, start;
  logic [PCW-1:0] load_addr;
  logic [31:0]    load_data;

  logic [PCW-1:0] pc, pc_s;
  logic           busy, busy_s, halted, halted_s, illegal, illegal_s;
  logic [DW-1:0]  dbg_a, dbg_b, dbg_result, dbg_a_s, dbg_b_s, dbg_result_s;
`ifdef BRANCH_STATS_EN
  logic [15:0]    taken_cnt, exec_cnt, taken_cnt_s, exec_cnt_s;
`endif

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk = ~clk;

  branch_seq_core #(.DATA_W(DW), .IMEM_DEPTH(32), .NREGS(32), .SIGNED_CMP(1'b0)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .load_en    (load_en),
    .load_addr  (load_addr),
    .load_data  (load_data),
    .start      (start),
    .pc         (pc),
    .busy       (busy),
    .halted     (halted),
    .illegal    (illegal),
    .dbg_a      (dbg_a),
    .dbg_b      (dbg_b),
    .dbg_result (dbg_result)
`ifdef BRANCH_STATS_EN
    ,
    .taken_cnt  (taken_cnt),
    .exec_cnt   (exec_cnt)
`endif
  );

  branch_seq_core #(.DATA_W(DW), .IMEM_DEPTH(32), .NREGS(32), .SIGNED_CMP(1'b1)) u_dut_s (
    .clk        (clk),
    .reset      (reset),
    .load_en    (load_en),
    .load_addr  (load_addr),
    .load_data  (load_data),
    .start      (start),
    .pc         (pc_s),
    .busy       (busy_s),
    .halted     (halted_s),
    .illegal    (illegal_s),
    .dbg_a      (dbg_a_s),
    .dbg_b      (dbg_b_s),
    .dbg_result (dbg_result_s)
`ifdef BRANCH_STATS_EN
    ,
    .taken_cnt  (taken_cnt_s),
    .exec_cnt   (exec_cnt_s)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load(input int addr, input logic [31:0] data);
    load_en   = 1'b1;
    load_addr = PCW'(addr);
    load_data = data;
    tick(1);
    load_en   = 1'b0;
  endtask

  task automatic start_pulse();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  function automatic logic [31:0] enc_r(input logic [5:0] op, input int rd, input int rs,
                                        input int rt);
    return {op, 5'(rd), 5'(rs), 5'(rt), 11'd0};
  endfunction

  function automatic logic [31:0] enc_b(input logic [5:0] op, input int rs, input int rd,
                                        input int imm);
    return {op, 5'(rd), 5'(rs), 16'(imm)};
  endfunction

  function automatic logic [31:0] enc_j(input logic [5:0] op, input int tgt);
    return {op, 26'(tgt)};
  endfunction

  logic [31:0] halt_w;
  logic [31:0] exp_pc   [12];
  logic [31:0] exp_pc_s [12];
  logic [31:0] exp_res  [12];

  initial begin
    halt_w    = {OP_HALT, 26'd0};
    exp_pc    = '{3, 4, 5, 6, 7, 8, 9, 12, 13, 14, 15, 15};
    exp_pc_s  = '{3, 4, 5, 6, 7, 8, 9, 12, 13, 14, 17, 17};
    exp_res   = '{0, 0, 4, 1, 5, 9, 4, 4, 4, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    reset     = 1'b0;
    load_en   = 1'b0;
    start     = 1'b0;
    load_addr = '0;
    load_data = '0;
    tick(2);
    check("rst_pc", 32'(pc), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_halted", 32'(halted), 0);
    check("rst_illegal", 32'(illegal), 0);
    check("rst_dbg_a", dbg_a, 0);
    check("rst_dbg_result", dbg_result, 0);
    reset = 1'b1;
    tick(1);

    // Program A: build R1=4, R2=5 from JAL/SLT, then add and branch.
    for (int i = 0; i < 32; i++) load(i, halt_w);
    load(0,  enc_j(OP_J, 3));
    load(3,  enc_j(OP_JAL, 4));
    load(4,  enc_r(OP_ADD, 1, 31, 0));
    load(5,  enc_r(OP_SLT, 5, 0, 1));
    load(6,  enc_r(OP_ADD, 2, 1, 5));
    load(7,  enc_r(OP_ADD, 3, 1, 2));
    load(8,  enc_r(OP_ADD, 29, 1, 0));
    load(9,  enc_b(OP_BEQ, 29, 31, 2));
    load(12, enc_b(OP_BNE, 29, 31, 5));
    load(13, enc_r(OP_SUB, 6, 0, 5));
    load(14, enc_b(OP_BLT, 6, 5, 2));
    check("load_idle_busy", 32'(busy), 0);
    start_pulse();
    check("start_busy", 32'(busy), 1);
    check("start_pc", 32'(pc), 0);
    for (int i = 0; i < 12; i++) begin
      tick(3);
      check($sformatf("a_pc[%0d]", i), 32'(pc), exp_pc[i]);
      check($sformatf("a_pc_s[%0d]", i), 32'(pc_s), exp_pc_s[i]);
      check($sformatf("a_res[%0d]", i), dbg_result, exp_res[i]);
      check($sformatf("a_halted[%0d]", i), 32'(halted), (i == 11) ? 32'd1 : 32'd0);
      if (i == 5) begin
        check("add_a", dbg_a, 4);
        check("add_b", dbg_b, 5);
      end
      if (i == 7) begin
        check("beq_a", dbg_a, 4);
        check("beq_b", dbg_b, 4);
      end
      if (i == 10) begin
        check("blt_a", dbg_a, 32'hFFFF_FFFF);
        check("blt_b", dbg_b, 1);
      end
    end
    check("a_busy_end", 32'(busy), 0);
    check("a_halted_s", 32'(halted_s), 1);
`ifdef BRANCH_STATS_EN
    check("taken_cnt", 32'(taken_cnt), 3);
    check("exec_cnt", 32'(exec_cnt), 12);
    check("taken_cnt_s", 32'(taken_cnt_s), 4);
`endif

    // Program B: J to 12, undefined opcode there; start/load while busy are ignored.
    load(0,  enc_j(OP_J, 9));
    load(9,  enc_j(OP_J, 12));
    load(12, {6'd5, 26'd0});
    start_pulse();
    tick(3);
    check("b_pc_j0", 32'(pc), 9);
    start     = 1'b1;
    load_en   = 1'b1;
    load_addr = PCW'(12);
    load_data = halt_w;
    tick(1);
    start     = 1'b0;
    load_en   = 1'b0;
    tick(2);
    check("b_pc_busy_start", 32'(pc), 12);
    tick(3);
    check("b_illegal", 32'(illegal), 1);
    check("b_halted", 32'(halted), 1);
    check("b_pc_hold", 32'(pc), 12);
    start_pulse();
    check("b_restart_illegal", 32'(illegal), 0);
    check("b_restart_pc", 32'(pc), 0);
    tick(9);
    check("b_busy_load_ignored", 32'(illegal), 1);

    // Program C: load and start together, wrap from 31 to 0, then reset during EXEC.
    load(31, enc_r(OP_ADD, 7, 1, 1));
    load_en   = 1'b1;
    load_addr = '0;
    load_data = enc_j(OP_J, 31);
    start     = 1'b1;
    tick(1);
    load_en   = 1'b0;
    start     = 1'b0;
    tick(3);
    check("c_load_first", 32'(pc), 31);
    tick(3);
    check("c_wrap_pc", 32'(pc), 0);
    check("c_wrap_res", dbg_result, 8);
    tick(3);
    check("c_jump_pc", 32'(pc), 31);
    tick(2);
    #2 reset = 1'b0;
    #1;
    check("c_rst_busy", 32'(busy), 0);
    check("c_rst_pc", 32'(pc), 0);
    check("c_rst_a", dbg_a, 0);
    check("c_rst_res", dbg_result, 0);
    tick(1);
    reset = 1'b1;
    tick(1);

    // Program D: R7 must read back as zero after the interrupted write.
    load(0, enc_r(OP_ADD, 9, 7, 1));
    load(1, halt_w);
    start_pulse();
    tick(3);
    check("d_pc", 32'(pc), 1);
    check("d_r7", dbg_a, 0);
    tick(3);
    check("d_halted", 32'(halted), 1);
    check("d_pc_hold", 32'(pc), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
